mem_load_align: RTL

MEM_LOAD_ALIGN -- requirements
Module: mem_load_align

---
 rtl/mem_load_align.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_load_align.sv
`timescale 1ns/1ps
// mem_load_align: tracks one outstanding load from EX, aligns the returned word and
// issues the write-back to WB. The bypass outputs are live only when MEM_LOAD_FWD_EN is defined.
module mem_load_align #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  aluop,
   input  logic [31:0] mem_addr,
   input  logic        in_exc,
   input  logic        in_wen,
   input  logic [4:0]  in_waddr,
   input  logic [31:0] in_wdata,
   input  logic        flush,
   input  logic        rdata_valid,
   input  logic [31:0] rdata,
   output logic        out_valid,
   output logic        out_wen,
   output logic [4:0]  out_waddr,
   output logic [31:0] out_wdata,
   output logic        pause_mem,
   output logic        timeout_err,
   output logic        fwd_valid,
   output logic [31:0] fwd_data
);

   localparam int unsigned CNT_W = 16;

   localparam logic [7:0] ALU_LDB  = 8'h20;
   localparam logic [7:0] ALU_LDH  = 8'h21;
   localparam logic [7:0] ALU_LDW  = 8'h22;
   localparam logic [7:0] ALU_LDBU = 8'h23;
   localparam logic [7:0] ALU_LDHU = 8'h24;
   localparam logic [7:0] ALU_LLW  = 8'h25;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   // Counter value seen in the last WAIT cycle allowed before timing out.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       op_q, op_d;
   logic [1:0]       off_q, off_d;
   logic             wen_q, wen_d;
   logic [4:0]       waddr_q, waddr_d;
   logic             out_valid_d, out_wen_d;
   logic [4:0]       out_waddr_d;
   logic [31:0]      out_wdata_d;
   logic             pause_c, timeout_c;
   logic             is_load, load_acc;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      align_data;
   logic             unused_addr;

   assign unused_addr = ^mem_addr[31:2];

   assign is_load  = (aluop == ALU_LDB)  || (aluop == ALU_LDBU) || (aluop == ALU_LDH) ||
                     (aluop == ALU_LDHU) || (aluop == ALU_LDW)  || (aluop == ALU_LLW);
   assign load_acc = in_valid && !in_exc && !flush && is_load;

   // Byte/half-word extraction and extension of the returned word.
   always_comb begin
      unique case (off_q)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = off_q[1] ? rdata[31:16] : rdata[15:0];
      case (op_q)
         ALU_LDB:  align_data = {{24{byte_sel[7]}}, byte_sel};
         ALU_LDBU: align_data = {24'd0, byte_sel};
         ALU_LDH:  align_data = {{16{half_sel[15]}}, half_sel};
         ALU_LDHU: align_data = {16'd0, half_sel};
         default:  align_data = rdata;
      endcase
   end

   // Next-state and write-back selection.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      off_d       = off_q;
      wen_d       = wen_q;
      waddr_d     = waddr_q;
      out_valid_d = 1'b0;
      out_wen_d   = 1'b0;
      out_waddr_d = '0;
      out_wdata_d = '0;
      pause_c     = 1'b0;
      timeout_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_acc) begin
               state_d = S_WAIT;
               cnt_d   = '0;
               op_d    = aluop;
               off_d   = mem_addr[1:0];
               wen_d   = in_wen;
               waddr_d = in_waddr;
               pause_c = 1'b1;
            end else if (in_valid && !flush && !is_load) begin
               out_valid_d = 1'b1;
               out_wen_d   = in_wen;
               out_waddr_d = in_waddr;
               out_wdata_d = in_wdata;
            end
         end
         S_WAIT: begin
            cnt_d   = cnt_q + CNT_W'(1);
            pause_c = !rdata_valid;
            if (rdata_valid) begin
               state_d = S_IDLE;
               if (!flush) begin
                  out_valid_d = 1'b1;
                  out_wen_d   = wen_q;
                  out_waddr_d = waddr_q;
                  out_wdata_d = align_data;
               end
            end else if (flush) begin
               state_d = S_DRAIN;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = S_IDLE;
               timeout_c = 1'b1;
            end
         end
         S_DRAIN: begin
            pause_c = 1'b1;
            if (rdata_valid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         off_q     <= '0;
         wen_q     <= 1'b0;
         waddr_q   <= '0;
         out_valid <= 1'b0;
         out_wen   <= 1'b0;
         out_waddr <= '0;
         out_wdata <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         off_q     <= off_d;
         wen_q     <= wen_d;
         waddr_q   <= waddr_d;
         out_valid <= out_valid_d;
         out_wen   <= out_wen_d;
         out_waddr <= out_waddr_d;
         out_wdata <= out_wdata_d;
      end
   end

   // Stall and timeout must react within the cycle, so they stay combinational.
   assign pause_mem   = rst & pause_c;
   assign timeout_err = rst & timeout_c;

`ifdef MEM_LOAD_FWD_EN
   assign fwd_valid = (state_q == S_WAIT) && rdata_valid && !flush;
   assign fwd_data  = align_data;
`else
   assign fwd_valid = 1'b0;
   assign fwd_data  = '0;
`endif

endmodule
